// File: rtl/pc_fetch_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_fetch_ctrl_pkg                                                |
// | Shared fetch-sequencer types: FSM states, entry selects, PC width |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package pc_fetch_ctrl_pkg;

  localparam int PC_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_PROG0 = 2'd0,
    SEL_PROG1 = 2'd1,
    SEL_PROG2 = 2'd2,
    SEL_ALT0  = 2'd3
  } prog_sel_t;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_fetch_ctrl_if                                                 |
// | Handshake, control and status bundle of the fetch sequencer      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface pc_fetch_ctrl_if
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int D  = PC_W,
  parameter int CW = 16
);
  logic          Start;
  logic [1:0]    Prog_sel;
  logic          Stall;
  logic          Halt;
  logic          Branch_en;
  logic          Branch_taken;
  logic [D-1:0]  Target;
  logic [D-1:0]  Prog_ctr;
  logic          Busy;
  logic          Done;
  logic          Err;
  logic [CW-1:0] Cycle_ct;
  logic [CW-1:0] Taken_ct;

  modport slave (
    input  Start, Prog_sel, Stall, Halt, Branch_en, Branch_taken, Target,
    output Prog_ctr, Busy, Done, Err, Cycle_ct, Taken_ct
  );

  modport master (
    output Start, Prog_sel, Stall, Halt, Branch_en, Branch_taken, Target,
    input  Prog_ctr, Busy, Done, Err, Cycle_ct, Taken_ct
  );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_ctrl_sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_fetch_ctrl_sat_counter                                        |
// | CW-bit up counter with clear, sticks at all-ones                 |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module pc_fetch_ctrl_sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);
  localparam logic [CW-1:0] C_MAX = '1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Clear wins over increment so a restart always begins from zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != C_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_fetch_ctrl                                                    |
// | Program counter, Start/Done fetch sequencer and run statistics   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int D          = PC_W,
  parameter int IMEM_DEPTH = 1024,
  parameter int START0     = 0,
  parameter int START1     = 0,
  parameter int START2     = 0,
  parameter int CW         = 16
) (
  input  logic           Clk,
  input  logic           Reset_n,
  pc_fetch_ctrl_if.slave bus
);
  localparam logic [D-1:0] C_START0 = D'(START0);
  localparam logic [D-1:0] C_START1 = D'(START1);
  localparam logic [D-1:0] C_START2 = D'(START2);
  localparam logic [D:0]   C_DEPTH  = (D+1)'(IMEM_DEPTH);

  state_t        state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic          err_q, err_d;
  logic          busy_q, done_q;
  logic          cyc_inc, cnt_clr, tkn_inc;
  logic          take_branch;
  logic [D-1:0]  entry_pc;
  logic signed [D:0] next_pc;
  logic          next_ok;

  always_comb begin
    case (prog_sel_t'(bus.Prog_sel))
      SEL_PROG1: entry_pc = C_START1;
      SEL_PROG2: entry_pc = C_START2;
      default:   entry_pc = C_START0;
    endcase
  end

  // One extra bit keeps backward branches past zero visibly negative.
  assign take_branch = bus.Branch_en & bus.Branch_taken;
  assign next_pc = take_branch
                 ? ($signed({1'b0, pc_q}) + $signed({bus.Target[D-1], bus.Target}))
                 : ($signed({1'b0, pc_q}) + $signed((D+1)'(1)));
  assign next_ok = (next_pc[D] == 1'b0) && ($unsigned(next_pc) < C_DEPTH);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    cyc_inc = 1'b0;
    cnt_clr = 1'b0;
    tkn_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          pc_d    = entry_pc;
          err_d   = 1'b0;
          cnt_clr = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cyc_inc = 1'b1;
        if (bus.Stall) begin
          state_d = ST_RUN;
        end else if (bus.Halt) begin
          state_d = ST_DONE;
        end else begin
          tkn_inc = take_branch;
          if (next_ok) begin
            pc_d = next_pc[D-1:0];
          end else begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (!bus.Start) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  pc_fetch_ctrl_sat_counter #(.CW(CW)) u_cycle_ct (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (cnt_clr),
    .inc   (cyc_inc),
    .count (bus.Cycle_ct)
  );

  pc_fetch_ctrl_sat_counter #(.CW(CW)) u_taken_ct (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (cnt_clr),
    .inc   (tkn_inc),
    .count (bus.Taken_ct)
  );

  assign bus.Prog_ctr = pc_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.Err      = err_q;
endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pc_fetch_ctrl                                                 |
// | Scoreboard bench for the fetch sequencer and saturating counter  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_pc_fetch_ctrl;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  pc_fetch_ctrl_if #(.D(12), .CW(16)) bus();

  pc_fetch_ctrl #(
    .D(12), .IMEM_DEPTH(1024), .START0(0), .START1(100), .START2(300), .CW(16)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  logic       sat_clr = 1'b0;
  logic       sat_inc = 1'b0;
  logic [2:0] sat_cnt;

  pc_fetch_ctrl_sat_counter #(.CW(3)) u_sat3 (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (sat_clr),
    .inc   (sat_inc),
    .count (sat_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [11:0] pc;
    logic        busy;
    logic        done;
    logic        err;
    int          cyc;
    int          tkn;   // negative: not compared
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [1:0] sel, input logic stall,
                       input logic halt, input logic ben, input logic btk,
                       input logic [11:0] tgt);
    bus.Start        = st;
    bus.Prog_sel     = sel;
    bus.Stall        = stall;
    bus.Halt         = halt;
    bus.Branch_en    = ben;
    bus.Branch_taken = btk;
    bus.Target       = tgt;
  endtask

  task automatic expect_out(input string tag, input logic [11:0] pc, input logic busy,
                            input logic done, input logic err, input int cyc, input int tkn);
    exp_t e;
    e.tag = tag; e.pc = pc; e.busy = busy; e.done = done; e.err = err;
    e.cyc = cyc; e.tkn = tkn;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".pc"},   32'(bus.Prog_ctr), 32'(e.pc));
      check({e.tag, ".busy"}, 32'(bus.Busy),     32'(e.busy));
      check({e.tag, ".done"}, 32'(bus.Done),     32'(e.done));
      check({e.tag, ".err"},  32'(bus.Err),      32'(e.err));
      check({e.tag, ".cyc"},  32'(bus.Cycle_ct), 32'(e.cyc));
      if (e.tkn >= 0) check({e.tag, ".tkn"}, 32'(bus.Taken_ct), 32'(e.tkn));
    end
  endtask

  // Drive one cycle of stimulus, queue the post-edge expectation, then compare.
  task automatic step(input string tag, input logic st, input logic [1:0] sel,
                      input logic stall, input logic halt, input logic ben,
                      input logic btk, input logic [11:0] tgt,
                      input logic [11:0] pc, input logic busy, input logic done,
                      input logic err, input int cyc, input int tkn);
    drive(st, sel, stall, halt, ben, btk, tgt);
    expect_out(tag, pc, busy, done, err, cyc, tkn);
    @(posedge Clk);
    #1;
    compare_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
    repeat (2) @(posedge Clk);
    #1;
    expect_out("reset", 12'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    compare_out();
    Reset_n = 1'b1;

    // Sequential program 2: 100..105 then halt
    step("seq_start", 1, 2'd1, 0, 0, 0, 0, 12'd0, 12'd100, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++)
      step($sformatf("seq%0d", k), 0, 2'd1, 0, 0, 0, 0, 12'd0,
           12'(100 + k), 1, 0, 0, k, 0);
    step("seq_halt", 0, 2'd1, 0, 1, 0, 0, 12'd0, 12'd105, 0, 1, 0, 6, 0);
    step("seq_idle", 0, 2'd1, 0, 0, 0, 0, 12'd0, 12'd105, 0, 0, 0, 6, 0);

    // Branches, stall/halt priority, self-loop
    step("br_start",   1, 2'd1, 0, 0, 0, 0, 12'd0,   12'd100, 1, 0, 0, 0, 0);
    step("br_fwd",     0, 2'd1, 0, 0, 1, 1, 12'd100, 12'd200, 1, 0, 0, 1, 1);
    step("br_back",    0, 2'd1, 0, 0, 1, 1, 12'hF4C, 12'd20,  1, 0, 0, 2, 2);
    step("br_fwd2",    0, 2'd1, 0, 0, 1, 1, 12'd180, 12'd200, 1, 0, 0, 3, 3);
    step("br_nottk",   0, 2'd1, 0, 0, 1, 0, 12'hF4C, 12'd201, 1, 0, 0, 4, 3);
    step("br_noen",    0, 2'd1, 0, 0, 0, 1, 12'hF4C, 12'd202, 1, 0, 0, 5, 3);
    step("stall_all",  0, 2'd1, 1, 1, 1, 1, 12'd5,   12'd202, 1, 0, 0, 6, 3);
    step("self_loop",  0, 2'd1, 0, 0, 1, 1, 12'd0,   12'd202, 1, 0, 0, 7, 4);
    step("halt_br",    0, 2'd1, 0, 1, 1, 1, 12'd5,   12'd202, 0, 1, 0, 8, 4);

    // Handshake: Start held through DONE, then low, then new program
    step("done_hold1", 1, 2'd2, 0, 0, 0, 0, 12'd0,   12'd202, 0, 1, 0, 8, 4);
    step("done_hold2", 1, 2'd2, 0, 0, 0, 0, 12'd0,   12'd202, 0, 1, 0, 8, 4);
    step("to_idle",    0, 2'd2, 0, 0, 0, 0, 12'd0,   12'd202, 0, 0, 0, 8, 4);
    step("p3_start",   1, 2'd2, 0, 0, 0, 0, 12'd0,   12'd300, 1, 0, 0, 0, 0);
    step("p3_br_top",  0, 2'd2, 0, 0, 1, 1, 12'd723, 12'd1023, 1, 0, 0, 1, 1);
    step("p3_overrun", 0, 2'd2, 0, 0, 0, 0, 12'd0,   12'd1023, 0, 1, 1, 2, 1);
    step("p3_idle",    0, 2'd2, 0, 0, 0, 0, 12'd0,   12'd1023, 0, 0, 1, 2, 1);

    // Negative range error; Start ignored in RUN
    step("p1_start",   1, 2'd0, 0, 0, 0, 0, 12'd0,   12'd0, 1, 0, 0, 0, 0);
    step("run_start",  1, 2'd2, 0, 0, 0, 0, 12'd0,   12'd1, 1, 0, 0, 1, 0);
    for (int k = 2; k <= 5; k++)
      step($sformatf("p1_seq%0d", k), 0, 2'd0, 0, 0, 0, 0, 12'd0,
           12'(k), 1, 0, 0, k, 0);
    step("neg_err",    0, 2'd0, 0, 0, 1, 1, 12'hFEF, 12'd5, 0, 1, 1, 6, -1);
    step("neg_idle",   0, 2'd0, 0, 0, 0, 0, 12'd0,   12'd5, 0, 0, 1, 6, -1);

    // Select 3 aliases entry 0; run to 37 and reset asynchronously
    step("sel3_start", 1, 2'd3, 0, 0, 0, 0, 12'd0,   12'd0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 37; k++)
      step($sformatf("run%0d", k), 0, 2'd3, 0, 0, 0, 0, 12'd0,
           12'(k), 1, 0, 0, k, 0);
    #3;
    Reset_n = 1'b0;
    #1;
    expect_out("async_rst", 12'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    compare_out();
    check("sat_reset", 32'(sat_cnt), 32'd0);

    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    sat_inc = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge Clk);
      #1;
      if (k == 3 || k == 7 || k == 10)
        check($sformatf("sat_inc%0d", k), 32'(sat_cnt), (k < 7) ? 32'(k) : 32'd7);
    end
    sat_clr = 1'b1;
    @(posedge Clk);
    #1;
    check("sat_clr", 32'(sat_cnt), 32'd0);
    sat_clr = 1'b0;
    sat_inc = 1'b0;
    expect_out("post_rst_idle", 12'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    compare_out();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
